// File: rtl/alu_fu_pkg.sv
// Shared types for the integer ALU functional unit and the RS-to-FU issue interface.
package alu_fu_pkg;

  localparam int REG_VAL_WIDTH          = 32;
  localparam int PHYSICAL_REG_NUM_WIDTH = 6;
  localparam int SHAMT_WIDTH            = $clog2(REG_VAL_WIDTH);

  // Encodings 11..15 are left undefined on purpose; the ALU returns zero for them.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASS2 = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
  } control_t;

endpackage

// File: rtl/FU_IF.sv
// Issue interface between the reservation stations and the functional units, one lane per FU.
interface FU_IF
  import alu_fu_pkg::*;
#(
  parameter int NUM_OF_FU = 4
);

  logic [NUM_OF_FU-1:0]              valid;
  logic [NUM_OF_FU-1:0]              ready;
  logic [REG_VAL_WIDTH-1:0]          src1_reg_val [NUM_OF_FU];
  logic [REG_VAL_WIDTH-1:0]          src2_reg_val [NUM_OF_FU];
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr [NUM_OF_FU];
  control_t                          control      [NUM_OF_FU];
  logic [REG_VAL_WIDTH-1:0]          immediate    [NUM_OF_FU];

  modport FU (
    input  valid, src1_reg_val, src2_reg_val, dst_reg_addr, control, immediate,
    output ready
  );

  modport RS (
    output valid, src1_reg_val, src2_reg_val, dst_reg_addr, control, immediate,
    input  ready
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational integer ALU datapath, shared by every FU that needs one.
module alu_core
  import alu_fu_pkg::*;
(
  input  alu_op_t                  i_op,
  input  logic [REG_VAL_WIDTH-1:0] i_src1,
  input  logic [REG_VAL_WIDTH-1:0] i_op2,
  output logic [REG_VAL_WIDTH-1:0] o_result
);

  logic [SHAMT_WIDTH-1:0] w_shamt;

  assign w_shamt = i_op2[SHAMT_WIDTH-1:0];

  // Result select; unknown encodings still produce a value so the op retires normally.
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_src1 + i_op2;
      ALU_SUB:   o_result = i_src1 - i_op2;
      ALU_AND:   o_result = i_src1 & i_op2;
      ALU_OR:    o_result = i_src1 | i_op2;
      ALU_XOR:   o_result = i_src1 ^ i_op2;
      ALU_SLL:   o_result = i_src1 << w_shamt;
      ALU_SRL:   o_result = i_src1 >> w_shamt;
      ALU_SRA:   o_result = $signed(i_src1) >>> w_shamt;
      ALU_SLT:   o_result = {{(REG_VAL_WIDTH-1){1'b0}}, ($signed(i_src1) < $signed(i_op2))};
      ALU_SLTU:  o_result = {{(REG_VAL_WIDTH-1){1'b0}}, (i_src1 < i_op2)};
      ALU_PASS2: o_result = i_op2;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_fu.sv
// Integer ALU functional unit: two-stage elastic pipeline (EX, WB) between RS issue and the CDB.
module alu_fu
  import alu_fu_pkg::*;
#(
  parameter int NUM_OF_FU = 4,
  parameter int FU_IDX    = 0
)(
  input  logic                              clk,
  input  logic                              rst_n,
  FU_IF.FU                                  fu_if,
  input  logic                              flush,
  output logic                              cdb_valid,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_dst_reg_addr,
  output logic [REG_VAL_WIDTH-1:0]          cdb_value,
  input  logic                              cdb_grant
);

  // An out-of-range lane index falls back to lane 0 instead of indexing past the interface.
  localparam int LANE = ((FU_IDX >= 0) && (FU_IDX < NUM_OF_FU)) ? FU_IDX : 0;

  logic                              r_ex_valid;
  logic [REG_VAL_WIDTH-1:0]          r_ex_src1;
  logic [REG_VAL_WIDTH-1:0]          r_ex_op2;
  alu_op_t                           r_ex_op;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_ex_dst;

  logic                              r_wb_valid;
  logic [REG_VAL_WIDTH-1:0]          r_wb_value;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] r_wb_dst;

  logic                              w_ex_advance;
  logic                              w_ready;
  logic                              w_issue;
  control_t                          w_ctrl;
  logic [REG_VAL_WIDTH-1:0]          w_op2;
  logic [REG_VAL_WIDTH-1:0]          w_ex_result;

  // Ready is a function of occupancy and grant only, so the RS never sees a valid->ready loop.
  assign w_ex_advance       = !r_wb_valid || cdb_grant;
  assign w_ready            = !r_ex_valid || w_ex_advance;
  assign w_issue            = fu_if.valid[LANE] && w_ready && !flush;
  assign fu_if.ready[LANE]  = w_ready;

  assign w_ctrl = fu_if.control[LANE];
  assign w_op2  = w_ctrl.alu_src ? fu_if.immediate[LANE] : fu_if.src2_reg_val[LANE];

  alu_core u_alu_core (
    .i_op     (r_ex_op),
    .i_src1   (r_ex_src1),
    .i_op2    (r_ex_op2),
    .o_result (w_ex_result)
  );

  // Execute stage: takes a new issue, otherwise empties when its op has moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_src1  <= '0;
      r_ex_op2   <= '0;
      r_ex_op    <= ALU_ADD;
      r_ex_dst   <= '0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_src1  <= fu_if.src1_reg_val[LANE];
      r_ex_op2   <= w_op2;
      r_ex_op    <= w_ctrl.alu_op;
      r_ex_dst   <= fu_if.dst_reg_addr[LANE];
    end else if (w_ex_advance) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= r_ex_valid;
    end
  end

  // Writeback stage: holds its result until granted; a grant during flush still counts as delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_value <= '0;
      r_wb_dst   <= '0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (w_ex_advance) begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_value <= w_ex_result;
        r_wb_dst   <= r_ex_dst;
      end else begin
        r_wb_value <= r_wb_value;
        r_wb_dst   <= r_wb_dst;
      end
    end else begin
      r_wb_valid <= r_wb_valid;
    end
  end

  assign cdb_valid        = r_wb_valid;
  assign cdb_value        = r_wb_value;
  assign cdb_dst_reg_addr = r_wb_dst;

endmodule

// File: tb/tb_alu_fu.sv
// Self-checking bench for alu_fu on lane 2: directed vectors, hand sequences and randomized traffic.
module tb_alu_fu;
  import alu_fu_pkg::*;

  localparam int NFU  = 4;
  localparam int LANE = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [5:0]  cdb_dst_reg_addr;
  logic [31:0] cdb_value;

  FU_IF #(.NUM_OF_FU(NFU)) u_if ();

  alu_fu #(.NUM_OF_FU(NFU), .FU_IDX(LANE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fu_if            (u_if),
    .flush            (flush),
    .cdb_valid        (cdb_valid),
    .cdb_dst_reg_addr (cdb_dst_reg_addr),
    .cdb_value        (cdb_value),
    .cdb_grant        (cdb_grant)
  );

  for (genvar g = 0; g < NFU; g++) begin : g_lane
    if (g != LANE) begin : g_tie
      assign u_if.ready[g] = 1'b0;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Issue-side stimulus for the lane under test
  logic        v_valid, v_alu_src, v_grant, v_flush, others_busy, last_acc;
  alu_op_t     v_op;
  logic [31:0] v_src1, v_src2, v_imm;
  logic [5:0]  v_dst;

  // Reference: ops in flight, oldest first; head visible on the CDB unless it entered on the last edge
  typedef struct { logic [31:0] val; logic [5:0] dst; } res_t;
  res_t mq[$];
  bit   m_fresh;

  typedef struct {
    alu_op_t op; logic [31:0] a; logic [31:0] b; logic [31:0] imm; logic si; logic [31:0] exp;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a + ~b + 32'd1;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << sh;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return a[31] ? ~((~a) >> sh) : (a >> sh);
      ALU_SLT:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASS2: return b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < NFU; i++) begin
      if (i != LANE) begin
        u_if.valid[i]           = others_busy ? 1'b1 : 1'($urandom_range(0, 1));
        u_if.src1_reg_val[i]    = 32'($urandom);
        u_if.src2_reg_val[i]    = 32'($urandom);
        u_if.immediate[i]       = 32'($urandom);
        u_if.dst_reg_addr[i]    = 6'($urandom_range(0, 63));
        u_if.control[i].alu_op  = alu_op_t'(4'($urandom_range(0, 15)));
        u_if.control[i].alu_src = 1'($urandom_range(0, 1));
      end
    end
    u_if.valid[LANE]           = v_valid;
    u_if.src1_reg_val[LANE]    = v_src1;
    u_if.src2_reg_val[LANE]    = v_src2;
    u_if.immediate[LANE]       = v_imm;
    u_if.dst_reg_addr[LANE]    = v_dst;
    u_if.control[LANE].alu_op  = v_op;
    u_if.control[LANE].alu_src = v_alu_src;
    cdb_grant = v_grant;
    flush     = v_flush;
  endtask

  task automatic set_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic si, input logic [5:0] dst);
    v_op = op; v_src1 = a; v_src2 = b; v_imm = imm; v_alu_src = si; v_dst = dst;
  endtask

  // One clock: check outputs against the reference, cross the edge, update the reference.
  task automatic tick(input logic [31:0] exp_res);
    bit exp_ready, exp_cv, acc;
    drive_lanes();
    #1;
    exp_ready = (mq.size() < 2) || v_grant;
    exp_cv    = (mq.size() > 1) || ((mq.size() == 1) && !m_fresh);
    chk("ready", 32'(u_if.ready[LANE]), 32'(exp_ready));
    chk("cdb_valid", 32'(cdb_valid), 32'(exp_cv));
    if (exp_cv) begin
      chk("cdb_value", cdb_value, mq[0].val);
      chk("cdb_dst", 32'(cdb_dst_reg_addr), 32'(mq[0].dst));
    end
    acc = v_valid && exp_ready && !v_flush;
    @(posedge clk);
    if (v_grant && exp_cv) void'(mq.pop_front());
    if (v_flush) mq.delete();
    else if (acc) mq.push_back('{val: exp_res, dst: v_dst});
    m_fresh  = acc;
    last_acc = acc;
    #1;
  endtask

  task automatic tick_m();
    tick(ref_alu(v_op, v_src1, v_alu_src ? v_imm : v_src2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{ALU_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h0,         1'b0, 32'h8000_0000};
    tbl[1]  = '{ALU_SUB,   32'h0000_0000, 32'h0000_0001, 32'h0,         1'b0, 32'hFFFF_FFFF};
    tbl[2]  = '{ALU_SRA,   32'h8000_0000, 32'h0000_0024, 32'h0,         1'b0, 32'hF800_0000};
    tbl[3]  = '{ALU_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         1'b0, 32'h0000_0001};
    tbl[4]  = '{ALU_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         1'b0, 32'h0000_0000};
    tbl[5]  = '{ALU_ADD,   32'h0000_000A, 32'h0000_0063, 32'h5,         1'b1, 32'h0000_000F};
    tbl[6]  = '{ALU_SLL,   32'h0000_0001, 32'h0000_0021, 32'h0,         1'b0, 32'h0000_0002};
    tbl[7]  = '{ALU_SRL,   32'h8000_0000, 32'h0000_001F, 32'h0,         1'b0, 32'h0000_0001};
    tbl[8]  = '{ALU_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0,         1'b0, 32'h00F0_00F0};
    tbl[9]  = '{ALU_OR,    32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0,         1'b0, 32'hFFFF_F0F0};
    tbl[10] = '{ALU_XOR,   32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,         1'b0, 32'hF0F0_0F0F};
    tbl[11] = '{ALU_PASS2, 32'h1234_5678, 32'h0000_0000, 32'hABCD_E000, 1'b1, 32'hABCD_E000};
    tbl[12] = '{alu_op_t'(4'd13), 32'h5,  32'h6,         32'h0,         1'b0, 32'h0000_0000};
    tbl[13] = '{ALU_SLT,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_0000};
    tbl[14] = '{ALU_SLTU,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_0001};
    tbl[15] = '{ALU_SRA,   32'h4000_0000, 32'h0000_001E, 32'h0,         1'b0, 32'h0000_0001};

    rst_n = 1'b0; v_valid = 1'b0; v_grant = 1'b0; v_flush = 1'b0; others_busy = 1'b0;
    last_acc = 1'b0; m_fresh = 1'b0;
    set_op(ALU_ADD, 32'h0, 32'h0, 32'h0, 1'b0, 6'd0);
    drive_lanes();
    #1;
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_ready", 32'(u_if.ready[LANE]), 32'd1);
    chk("rst_cdb_value", cdb_value, 32'd0);
    chk("rst_cdb_dst", 32'(cdb_dst_reg_addr), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back with constant grant
    v_grant = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v_valid = 1'b1;
      set_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].si, 6'(i + 1));
      tick(tbl[i].exp);
    end
    v_valid = 1'b0;
    repeat (2) tick_m();

    // Back-pressure: three issues with grant low, third stalls until grant rises
    v_grant = 1'b0; v_valid = 1'b1;
    set_op(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 6'd40); tick_m();
    set_op(ALU_SUB, 32'd9, 32'd4, 32'd0, 1'b0, 6'd41); tick_m();
    set_op(ALU_XOR, 32'hFF, 32'h0F, 32'd0, 1'b0, 6'd42);
    tick_m();
    chk("bp_third_stalled", 32'(last_acc), 32'd0);
    tick_m();
    v_grant = 1'b1; tick_m();
    chk("bp_third_taken", 32'(last_acc), 32'd1);
    v_valid = 1'b0;
    repeat (3) tick_m();

    // Async reset with both stages full
    v_grant = 1'b0; v_valid = 1'b1;
    set_op(ALU_OR, 32'hF0, 32'h0F, 32'd0, 1'b0, 6'd50); tick_m();
    set_op(ALU_AND, 32'hF0, 32'hFF, 32'd0, 1'b0, 6'd51); tick_m();
    chk("pre_rst_full", 32'(cdb_valid), 32'd1);
    v_valid = 1'b0; drive_lanes();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("mid_rst_ready", 32'(u_if.ready[LANE]), 32'd1);
    chk("mid_rst_cdb_value", cdb_value, 32'd0);
    mq.delete(); m_fresh = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (2) tick_m();

    // Flush with both stages full, an issue pending and a grant in the same cycle
    v_grant = 1'b0; v_valid = 1'b1;
    set_op(ALU_ADD, 32'd100, 32'd1, 32'd0, 1'b0, 6'd60); tick_m();
    set_op(ALU_ADD, 32'd200, 32'd2, 32'd0, 1'b0, 6'd61); tick_m();
    set_op(ALU_ADD, 32'd300, 32'd3, 32'd0, 1'b0, 6'd62);
    v_grant = 1'b1; v_flush = 1'b1; tick_m();
    v_flush = 1'b0; v_valid = 1'b0;
    tick_m();
    chk("flush_cdb_cleared", 32'(cdb_valid), 32'd0);
    repeat (2) tick_m();
    // Flush without grant
    v_grant = 1'b0; v_valid = 1'b1;
    set_op(ALU_SUB, 32'd7, 32'd3, 32'd0, 1'b0, 6'd63); tick_m();
    set_op(ALU_SLL, 32'd3, 32'd2, 32'd0, 1'b0, 6'd1);  tick_m();
    v_flush = 1'b1; tick_m();
    v_flush = 1'b0; v_valid = 1'b0;
    repeat (2) tick_m();

    // Lane isolation: other lanes always valid, lane 2 idle; ready[2] follows grant once full
    others_busy = 1'b1; v_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v_grant = 1'(k % 2);
      tick_m();
    end
    v_grant = 1'b0; v_valid = 1'b1;
    set_op(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 6'd5); tick_m();
    set_op(ALU_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 6'd6); tick_m();
    v_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      v_grant = 1'(k % 2);
      tick_m();
    end
    others_busy = 1'b0;

    // Randomized traffic; a refused issue is held stable as the RS would
    for (int k = 0; k < 400; k++) begin
      if (!(v_valid && !last_acc)) begin
        v_valid = ($urandom_range(0, 3) != 0);
        set_op(alu_op_t'(4'($urandom_range(0, 15))), rval(), rval(), rval(),
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
      end
      v_grant = ($urandom_range(0, 9) < 7);
      v_flush = ($urandom_range(0, 24) == 0);
      tick_m();
    end
    v_valid = 1'b0; v_flush = 1'b0; v_grant = 1'b1;
    repeat (3) tick_m();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
